// File: rtl/ma_channel_scheduler_if.sv
// Handshake bundle around the moving-average channel scheduler.
// master: environment side (sample sources, result sinks, shared engine); slave: the scheduler.
// Groups: req_*/ch_clear per-channel inputs, eng_* engine issue/return, res_* per-channel results.
interface ma_channel_scheduler_if #(
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int DW  = 8
);
  logic [NCH-1:0]    req_valid;   // per-channel sample valid
  logic [NCH*DW-1:0] req_data;    // channel i at [i*DW +: DW], signed
  logic [NCH-1:0]    req_ready;   // one-hot or zero grant
  logic [NCH-1:0]    ch_clear;    // per-channel clear level
  logic              eng_valid;   // sample issue strobe
  logic              eng_clr;     // window clear strobe for eng_ch
  logic [CHW-1:0]    eng_ch;      // channel tag for issue/clear
  logic [DW-1:0]     eng_data;    // issued sample
  logic [DW-1:0]     eng_result;  // engine average, LAT cycles after issue
  logic [NCH-1:0]    res_valid;   // one-cycle result pulse per channel
  logic [NCH*DW-1:0] res_data;    // last result per channel, held
  logic [NCH-1:0]    res_primed;  // channel window is full

  modport master (
    output req_valid, req_data, ch_clear, eng_result,
    input  req_ready, eng_valid, eng_clr, eng_ch, eng_data,
           res_valid, res_data, res_primed
  );

  modport slave (
    input  req_valid, req_data, ch_clear, eng_result,
    output req_ready, eng_valid, eng_clr, eng_ch, eng_data,
           res_valid, res_data, res_primed
  );
endinterface

// File: rtl/ma_channel_scheduler.sv
// Round-robin scheduler sharing one fixed-latency moving-average engine across NCH channels.
// Latency: request handshake -> engine issue 1 cycle; handshake -> res_valid 1+LAT cycles.
// Backpressure: at most one req_ready per cycle; clears win over grants; cleared channels stall.
// Ports: system1000/system1000_rstn clock and async active-low reset; bus (slave modport)
//   carries the per-channel request/clear inputs, the engine issue/return pair and the
//   per-channel result/primed outputs.
module ma_channel_scheduler #(
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int DW  = 8,
  parameter int LAT = 1,
  parameter int WIN = 4
) (
  input  logic                  system1000,
  input  logic                  system1000_rstn,
  ma_channel_scheduler_if.slave bus
);

  localparam int CNTW = $clog2(WIN + 1);

  // Registered state
  logic [CHW-1:0]            ptr_q,       ptr_d;
  logic                      eng_valid_q, eng_valid_d;
  logic                      eng_clr_q,   eng_clr_d;
  logic [CHW-1:0]            eng_ch_q,    eng_ch_d;
  logic [DW-1:0]             eng_data_q,  eng_data_d;
  logic [LAT-1:0]            tag_vld_q,   tag_vld_d;
  logic [LAT-1:0][CHW-1:0]   tag_ch_q,    tag_ch_d;
  logic [NCH-1:0][CNTW-1:0]  cnt_q,       cnt_d;
  logic [NCH-1:0]            primed_q,    primed_d;
  logic [NCH-1:0][DW-1:0]    res_data_q,  res_data_d;

  // Combinational arbitration / return decode
  logic [NCH-1:0][DW-1:0]    req_arr;
  logic [NCH-1:0]            cand;
  logic                      clr_any;
  logic [CHW-1:0]            clr_idx;
  logic                      gnt_any;
  logic [CHW-1:0]            gnt_idx;
  logic [CHW-1:0]            rr_idx;
  logic [DW-1:0]             gnt_sample;
  logic [NCH-1:0]            ret_hit;

  assign req_arr = bus.req_data;

  // Clear selection and rotating-priority grant.
  always_comb begin : arb_comb
    cand    = bus.req_valid & ~bus.ch_clear;
    clr_any = |bus.ch_clear;
    clr_idx = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    // Descending scan so the lowest set clear bit is the one left standing.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.ch_clear[i]) clr_idx = CHW'(i);
    end
    // Scan offsets from the pointer downward so the nearest candidate at or
    // above the pointer (with wrap) overwrites any farther one.
    for (int k = NCH - 1; k >= 0; k--) begin
      rr_idx = CHW'((int'(ptr_q) + k) % NCH);
      if (cand[rr_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx;
      end
    end
    // A pending clear consumes the engine slot this cycle.
    if (clr_any) gnt_any = 1'b0;
    gnt_sample = req_arr[gnt_idx];
  end

  // Gating with reset keeps req_ready low while the block is held in reset.
  assign bus.req_ready = (gnt_any && system1000_rstn) ? (NCH'(1) << gnt_idx) : '0;

  // Issue stage, pointer and warm-up counters.
  always_comb begin : issue_comb
    ptr_d       = ptr_q;
    eng_valid_d = 1'b0;
    eng_clr_d   = 1'b0;
    eng_ch_d    = eng_ch_q;
    eng_data_d  = eng_data_q;
    cnt_d       = cnt_q;
    if (clr_any) begin
      eng_clr_d      = 1'b1;
      eng_ch_d       = clr_idx;
      cnt_d[clr_idx] = '0;
    end else if (gnt_any) begin
      eng_valid_d = 1'b1;
      eng_ch_d    = gnt_idx;
      eng_data_d  = gnt_sample;
      ptr_d       = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
      if (cnt_q[gnt_idx] != CNTW'(WIN)) cnt_d[gnt_idx] = cnt_q[gnt_idx] + CNTW'(1);
    end
    // Primed is registered from the next count so it rises together with
    // eng_valid of the WIN-th sample and falls together with eng_clr.
    for (int i = 0; i < NCH; i++) begin
      primed_d[i] = (cnt_d[i] == CNTW'(WIN));
    end
  end

  // Tag pipeline mirrors the engine latency; only sample issues carry a tag,
  // clears do not produce results.
  always_comb begin : tag_comb
    tag_vld_d    = tag_vld_q;
    tag_ch_d     = tag_ch_q;
    tag_vld_d[0] = eng_valid_q;
    tag_ch_d[0]  = eng_ch_q;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i - 1];
      tag_ch_d[i]  = tag_ch_q[i - 1];
    end
  end

  // Return routing: the tail tag picks the owning channel. res_data shows the
  // engine value in the pulse cycle and the register keeps it afterwards.
  always_comb begin : ret_comb
    ret_hit    = '0;
    res_data_d = res_data_q;
    if (tag_vld_q[LAT - 1]) ret_hit[tag_ch_q[LAT - 1]] = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (ret_hit[i]) res_data_d[i] = bus.eng_result;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      ptr_q       <= '0;
      eng_valid_q <= 1'b0;
      eng_clr_q   <= 1'b0;
      eng_ch_q    <= '0;
      eng_data_q  <= '0;
      tag_vld_q   <= '0;
      tag_ch_q    <= '0;
      cnt_q       <= '0;
      primed_q    <= '0;
      res_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      eng_valid_q <= eng_valid_d;
      eng_clr_q   <= eng_clr_d;
      eng_ch_q    <= eng_ch_d;
      eng_data_q  <= eng_data_d;
      tag_vld_q   <= tag_vld_d;
      tag_ch_q    <= tag_ch_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.eng_valid  = eng_valid_q;
  assign bus.eng_clr    = eng_clr_q;
  assign bus.eng_ch     = eng_ch_q;
  assign bus.eng_data   = eng_data_q;
  assign bus.res_valid  = ret_hit;
  assign bus.res_data   = res_data_d;
  assign bus.res_primed = primed_q;

endmodule

// File: tb/tb_ma_channel_scheduler.sv
// Bench for ma_channel_scheduler: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level model (pointer, counters,
// queue of pending results) with a stand-in engine of depth LAT.
module tb_ma_channel_scheduler;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int DW  = 8;
  localparam int LAT = 3;
  localparam int WIN = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ma_channel_scheduler_if #(.NCH(NCH), .CHW(CHW), .DW(DW)) bus ();

  ma_channel_scheduler #(.NCH(NCH), .CHW(CHW), .DW(DW), .LAT(LAT), .WIN(WIN)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus)
  );

  // Stand-in engine: a channel-dependent transform delayed by LAT cycles.
  function automatic logic [DW-1:0] eng_fn(input logic [DW-1:0] x, input int ch);
    return x + DW'(ch * 37 + 11);
  endfunction

  logic [DW-1:0] epd [LAT];
  always @(posedge clk) begin
    epd[0] <= bus.eng_valid ? eng_fn(bus.eng_data, int'(bus.eng_ch)) : DW'('hA5);
    for (int i = 1; i < LAT; i++) epd[i] <= epd[i - 1];
  end
  assign bus.eng_result = epd[LAT - 1];

  // Reference model state
  typedef struct {
    int            due;
    int            ch;
    logic [DW-1:0] val;
  } pend_t;

  pend_t         pend [$];
  int            ptr;
  int            cnt  [NCH];
  logic [DW-1:0] last [NCH];
  logic          m_ev, m_ec;
  int            m_ech;
  logic [DW-1:0] m_ed;
  int            cyc;
  int            n_chk  = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[NCH*DW-1:0];
  endfunction

  function automatic logic [NCH*DW-1:0] set_lane(input logic [NCH*DW-1:0] d, input int ch,
                                                 input logic [DW-1:0] v);
    logic [NCH*DW-1:0] o;
    o = d;
    o[ch*DW +: DW] = v;
    return o;
  endfunction

  function automatic void model_clear();
    ptr  = 0;
    m_ev = 1'b0;
    m_ec = 1'b0;
    m_ech = 0;
    m_ed = '0;
    pend.delete();
    for (int i = 0; i < NCH; i++) begin
      cnt[i]  = 0;
      last[i] = '0;
    end
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                       input logic [NCH-1:0] c);
    logic [NCH-1:0]    er, erv, epr;
    logic [NCH*DW-1:0] erd;
    int                k, g;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.ch_clear  = c;
    @(negedge clk);
    k = -1;
    g = -1;
    for (int i = 0; i < NCH; i++) begin
      if (c[i]) begin k = i; break; end
    end
    if (k < 0) begin
      for (int off = 0; off < NCH; off++) begin
        int j;
        j = (ptr + off) % NCH;
        if (v[j] && !c[j]) begin g = j; break; end
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    chk("eng_valid", bus.eng_valid, m_ev);
    chk("eng_clr",   bus.eng_clr,   m_ec);
    chk("eng_ch",    bus.eng_ch,    m_ech);
    chk("eng_data",  bus.eng_data,  m_ed);
    erv = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      erv[pend[0].ch]  = 1'b1;
      last[pend[0].ch] = pend[0].val;
      void'(pend.pop_front());
    end
    for (int i = 0; i < NCH; i++) begin
      erd[i*DW +: DW] = last[i];
      epr[i]          = (cnt[i] == WIN);
    end
    chk("res_valid",  bus.res_valid,  erv);
    chk("res_data",   bus.res_data,   erd);
    chk("res_primed", bus.res_primed, epr);
    if (k >= 0) begin
      m_ev   = 1'b0;
      m_ec   = 1'b1;
      m_ech  = k;
      cnt[k] = 0;
    end else if (g >= 0) begin
      m_ev  = 1'b1;
      m_ec  = 1'b0;
      m_ech = g;
      m_ed  = d[g*DW +: DW];
      if (cnt[g] < WIN) cnt[g]++;
      ptr = (g + 1) % NCH;
      pend.push_back('{cyc + 1 + LAT, g, eng_fn(m_ed, g)});
    end else begin
      m_ev = 1'b0;
      m_ec = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Reset held for ncyc cycles with requests pending; every output must read zero.
  task automatic do_reset(input int ncyc);
    rstn = 1'b0;
    model_clear();
    bus.req_valid = '1;
    bus.ch_clear  = '0;
    bus.req_data  = rnd_data();
    repeat (ncyc) begin
      @(negedge clk);
      chk("rst_req_ready",  bus.req_ready,  '0);
      chk("rst_eng_valid",  bus.eng_valid,  '0);
      chk("rst_eng_clr",    bus.eng_clr,    '0);
      chk("rst_eng_ch",     bus.eng_ch,     '0);
      chk("rst_eng_data",   bus.eng_data,   '0);
      chk("rst_res_valid",  bus.res_valid,  '0);
      chk("rst_res_data",   bus.res_data,   '0);
      chk("rst_res_primed", bus.res_primed, '0);
      cyc++;
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0, rnd_data(), '0);
  endtask

  initial begin
    logic [NCH*DW-1:0] d;
    cyc = 0;
    model_clear();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.ch_clear  = '0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Single channel 1 with sample -5.
    d = set_lane(rnd_data(), 1, DW'(-5));
    repeat (3) cycle(4'b0010, d, '0);
    idle(LAT + 2);

    // All channels continuously valid from pointer 0.
    do_reset(1);
    repeat (8) cycle(4'b1111, rnd_data(), '0);
    idle(LAT + 2);

    // Warm-up on channel 2 only, including one sample past saturation.
    do_reset(1);
    repeat (5) cycle(4'b0100, rnd_data(), '0);
    idle(LAT + 2);

    // Clear collides with requests; channel 0 wins afterwards.
    cycle(4'b0101, rnd_data(), 4'b0100);
    cycle(4'b0101, rnd_data(), '0);
    idle(LAT + 2);

    // Result in flight while its channel is cleared.
    cycle(4'b1000, rnd_data(), '0);
    cycle('0, rnd_data(), 4'b1000);
    idle(LAT + 2);

    // Reset with two samples in flight; nothing may emerge afterwards.
    cycle(4'b0011, rnd_data(), '0);
    cycle(4'b0011, rnd_data(), '0);
    cycle('0, rnd_data(), '0);
    do_reset(2);
    idle(5);
    cycle(4'b1111, rnd_data(), '0);
    idle(LAT + 2);

    // Random traffic with occasional clears and resets.
    for (int n = 0; n < 800; n++) begin
      logic [NCH-1:0] v, c;
      v = NCH'($urandom);
      c = '0;
      if ($urandom_range(0, 5) == 0) c = NCH'($urandom) & NCH'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset(1);
      else cycle(v, rnd_data(), c);
    end
    idle(LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
